imem_loader: RTL and testbench

Program loader that writes instruction memory, the write-side counterpart of the fetch stage's instruction-memory read path. It accepts a framed byte stream (start byte, word count, big-endian instruction words, checksum), assembles 32-bit words and issues single-cycle writes to the instruction memory. It holds the core (`CPU_HOLD`, used to force PC_WRITE low and flush IF/ID) for the whole load. It sits between the host byte receiver and the instruction memory write port.

---
 rtl/imem_loader_if.sv | 37 +++
 rtl/imem_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_loader.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream in, instruction memory write port
// and loader status out.
interface imem_loader_if;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        CPU_HOLD;
  logic        LOAD_DONE;
  logic        LOAD_ERR;
  logic [15:0] WORD_CNT;

  modport master (
    output RX_DATA,
    output RX_VALID,
    input  MEM_WE,
    input  MEM_ADDR,
    input  MEM_WDATA,
    input  CPU_HOLD,
    input  LOAD_DONE,
    input  LOAD_ERR,
    input  WORD_CNT
  );

  modport slave (
    input  RX_DATA,
    input  RX_VALID,
    output MEM_WE,
    output MEM_ADDR,
    output MEM_WDATA,
    output CPU_HOLD,
    output LOAD_DONE,
    output LOAD_ERR,
    output WORD_CNT
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream to instruction memory writer.
// Holds the core for the whole load; releases only on a good frame.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [7:0]  START_BYTE     = 8'hA5,
  parameter int          MAX_WORDS      = 256,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input logic         CLK,
  input logic         RST,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   len_new;
  logic [23:0]   shift_q, shift_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   wc_q, wc_d;
  logic [15:0]   wc_inc;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          in_frame;
  logic          v;
  logic [7:0]    b;

  assign v      = bus.RX_VALID;
  assign b      = bus.RX_DATA;
  assign wc_inc = wc_q + 16'd1;

  // Next-state and next-output decode for the frame parser
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    len_new  = {len_q[15:8], b};
    shift_d  = shift_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    timer_d  = timer_q;
    wc_d     = wc_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;
    in_frame = (state_q != IDLE);

    if (in_frame) begin
      if (v) timer_d = '0;
      else   timer_d = timer_q + TW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (v && b == START_BYTE) begin
          state_d = LEN_HI;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wc_d    = '0;
          idx_d   = '0;
          csum_d  = '0;
          timer_d = '0;
        end
      end
      LEN_HI: begin
        if (v) begin
          len_d   = {b, 8'h00};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (v) begin
          len_d = len_new;
          if ({1'b0, len_new} > MAX_LEN) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else if (len_new == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (v) begin
          shift_d = {shift_q[15:0], b};
          csum_d  = csum_q + b;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {shift_q, b};
            addr_d  = BASE_ADDR + {14'd0, wc_q, 2'b00};
            wc_d    = wc_inc;
            if (wc_inc == len_q) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (v) begin
          state_d = IDLE;
          if (b == csum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe in the same cycle beats the timeout
    if (in_frame && !v && timer_q == T_LAST) begin
      state_d = IDLE;
      err_d   = 1'b1;
      timer_d = '0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      len_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      timer_q <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      timer_q <= timer_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.MEM_WE    = we_q;
  assign bus.MEM_ADDR  = addr_q;
  assign bus.MEM_WDATA = wdata_q;
  assign bus.CPU_HOLD  = hold_q;
  assign bus.LOAD_DONE = done_q;
  assign bus.LOAD_ERR  = err_q;
  assign bus.WORD_CNT  = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against imem_loader.
// A second instance checks 32-bit address wrap from the top of memory.
module tb_imem_loader;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  imem_loader_if bus();
  imem_loader_if bus2();

  imem_loader #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  imem_loader #(
    .BASE_ADDR(32'hFFFF_FFFC),
    .TIMEOUT_CYCLES(16)
  ) dut2 (
    .CLK(CLK),
    .RST(RST),
    .bus(bus2)
  );

  assign bus2.RX_DATA  = bus.RX_DATA;
  assign bus2.RX_VALID = bus.RX_VALID;

  always #5 CLK = ~CLK;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] wa2[$];
  logic [7:0]  seq[$];

  // Write monitors
  always @(negedge CLK) begin
    if (bus.MEM_WE === 1'b1) begin
      wa.push_back(bus.MEM_ADDR);
      wd.push_back(bus.MEM_WDATA);
    end
    if (bus2.MEM_WE === 1'b1) wa2.push_back(bus2.MEM_ADDR);
  end

  task automatic send_byte(input logic [7:0] b);
    bus.RX_DATA  = b;
    bus.RX_VALID = 1'b1;
    @(negedge CLK);
    bus.RX_VALID = 1'b0;
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wa2.delete();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_tests++;
    if ({bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA} !== 65'd0) begin
      n_fail++;
      $display("FAIL rst_mem got we=%0b a=%h d=%h want 0",
               bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA);
    end
    n_tests++;
    if ({bus.CPU_HOLD, bus.LOAD_DONE, bus.LOAD_ERR} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flags got %b want 000",
               {bus.CPU_HOLD, bus.LOAD_DONE, bus.LOAD_ERR});
    end
    n_tests++;
    if (bus.WORD_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_cnt got %0d want 0", bus.WORD_CNT);
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_good_frame();
    clear_log();
    send_byte(8'hA5);
    n_tests++;
    if (bus.CPU_HOLD !== 1'b1) begin
      n_fail++;
      $display("FAIL start_hold got %b want 1", bus.CPU_HOLD);
    end
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    n_tests++;
    if (bus.MEM_WE !== 1'b0) begin
      n_fail++;
      $display("FAIL early_we got %b want 0", bus.MEM_WE);
    end
    send_byte(8'h78);
    n_tests++;
    if ({bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA, bus.WORD_CNT} !==
        {1'b1, 32'h0, 32'h1234_5678, 16'd1}) begin
      n_fail++;
      $display("FAIL word0 got we=%b a=%h d=%h n=%0d want 1 0 12345678 1",
               bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA, bus.WORD_CNT);
    end
    send_byte(8'h9A);
    n_tests++;
    if (bus.MEM_WE !== 1'b0) begin
      n_fail++;
      $display("FAIL we_width got %b want 0", bus.MEM_WE);
    end
    send_byte(8'hBC);
    send_byte(8'hDE);
    send_byte(8'hF0);
    n_tests++;
    if ({bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA} !==
        {1'b1, 32'h4, 32'h9ABC_DEF0}) begin
      n_fail++;
      $display("FAIL word1 got we=%b a=%h d=%h want 1 4 9abcdef0",
               bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA);
    end
    // data bytes sum to 0x438 -> 0x38
    send_byte(8'h38);
    n_tests++;
    if ({bus.LOAD_DONE, bus.LOAD_ERR, bus.CPU_HOLD} !== 3'b100) begin
      n_fail++;
      $display("FAIL good_flags got done/err/hold=%b want 100",
               {bus.LOAD_DONE, bus.LOAD_ERR, bus.CPU_HOLD});
    end
    n_tests++;
    if ({16'(wa.size()), bus.WORD_CNT} !== {16'd2, 16'd2}) begin
      n_fail++;
      $display("FAIL good_count got writes=%0d cnt=%0d want 2 2",
               wa.size(), bus.WORD_CNT);
    end
    n_tests++;
    if ({32'(wa2.size()), wa2[0], wa2[1]} !==
        {32'd2, 32'hFFFF_FFFC, 32'h0}) begin
      n_fail++;
      $display("FAIL addr_wrap got n=%0d a0=%h a1=%h want 2 fffffffc 0",
               wa2.size(), wa2[0], wa2[1]);
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    seq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
            8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h39};
    send_seq();
    n_tests++;
    if ({32'(wd.size()), wd[1]} !== {32'd2, 32'h9ABC_DEF0}) begin
      n_fail++;
      $display("FAIL bad_writes got n=%0d d1=%h want 2 9abcdef0",
               wd.size(), wd[1]);
    end
    n_tests++;
    if ({bus.LOAD_DONE, bus.LOAD_ERR, bus.CPU_HOLD} !== 3'b011) begin
      n_fail++;
      $display("FAIL bad_flags got done/err/hold=%b want 011",
               {bus.LOAD_DONE, bus.LOAD_ERR, bus.CPU_HOLD});
    end
  endtask

  task automatic test_oversize();
    clear_log();
    seq = '{8'hA5, 8'h01, 8'h01};
    send_seq();
    n_tests++;
    if ({bus.LOAD_DONE, bus.LOAD_ERR, bus.CPU_HOLD} !== 3'b011) begin
      n_fail++;
      $display("FAIL big_flags got done/err/hold=%b want 011",
               {bus.LOAD_DONE, bus.LOAD_ERR, bus.CPU_HOLD});
    end
    seq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_seq();
    repeat (2) @(negedge CLK);
    n_tests++;
    if ({32'(wa.size()), bus.WORD_CNT, bus.LOAD_ERR} !==
        {32'd0, 16'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL big_ignore got writes=%0d cnt=%0d err=%b want 0 0 1",
               wa.size(), bus.WORD_CNT, bus.LOAD_ERR);
    end
  endtask

  task automatic test_zero_length();
    clear_log();
    seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_seq();
    n_tests++;
    if ({bus.LOAD_DONE, bus.LOAD_ERR, bus.CPU_HOLD} !== 3'b100) begin
      n_fail++;
      $display("FAIL zero_flags got done/err/hold=%b want 100",
               {bus.LOAD_DONE, bus.LOAD_ERR, bus.CPU_HOLD});
    end
    n_tests++;
    if (wa.size() != 0) begin
      n_fail++;
      $display("FAIL zero_writes got %0d want 0", wa.size());
    end
  endtask

  task automatic test_start_as_data();
    clear_log();
    seq = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h94};
    send_seq();
    n_tests++;
    if ({32'(wd.size()), wa[0], wd[0]} !==
        {32'd1, 32'h0, 32'hA5A5_A5A5}) begin
      n_fail++;
      $display("FAIL a5_data got n=%0d a=%h d=%h want 1 0 a5a5a5a5",
               wd.size(), wa[0], wd[0]);
    end
    n_tests++;
    if ({bus.LOAD_DONE, bus.LOAD_ERR, bus.WORD_CNT} !== {2'b10, 16'd1}) begin
      n_fail++;
      $display("FAIL a5_flags got done=%b err=%b n=%0d want 1 0 1",
               bus.LOAD_DONE, bus.LOAD_ERR, bus.WORD_CNT);
    end
  endtask

  task automatic test_timeout();
    clear_log();
    seq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
    send_seq();
    repeat (15) @(negedge CLK);
    n_tests++;
    if (bus.LOAD_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL to_early got err=%b want 0", bus.LOAD_ERR);
    end
    @(negedge CLK);
    n_tests++;
    if ({bus.LOAD_ERR, bus.CPU_HOLD, 32'(wa.size())} !==
        {2'b11, 32'd0}) begin
      n_fail++;
      $display("FAIL to_expire got err=%b hold=%b writes=%0d want 1 1 0",
               bus.LOAD_ERR, bus.CPU_HOLD, wa.size());
    end
    // DE+AD+BE+EF = 0x338 -> 0x38
    seq = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
    send_seq();
    n_tests++;
    if ({bus.LOAD_DONE, bus.LOAD_ERR, bus.CPU_HOLD} !== 3'b100) begin
      n_fail++;
      $display("FAIL to_recover got done/err/hold=%b want 100",
               {bus.LOAD_DONE, bus.LOAD_ERR, bus.CPU_HOLD});
    end
    n_tests++;
    if (wd[0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL to_word got %h want deadbeef", wd[0]);
    end
  endtask

  task automatic test_gap_limit();
    seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    foreach (seq[i]) begin
      send_byte(seq[i]);
      if (i < 3) repeat (15) @(negedge CLK);
    end
    n_tests++;
    if ({bus.LOAD_DONE, bus.LOAD_ERR} !== 2'b10) begin
      n_fail++;
      $display("FAIL gap15 got done/err=%b want 10",
               {bus.LOAD_DONE, bus.LOAD_ERR});
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    seq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    send_seq();
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    n_tests++;
    if ({bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA, bus.CPU_HOLD,
         bus.LOAD_DONE, bus.LOAD_ERR, bus.WORD_CNT} !== 84'd0) begin
      n_fail++;
      $display("FAIL rmid_outs got we=%b a=%h d=%h hold=%b n=%0d want 0",
               bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA, bus.CPU_HOLD,
               bus.WORD_CNT);
    end
    n_tests++;
    if (wa.size() != 1) begin
      n_fail++;
      $display("FAIL rmid_writes got %0d want 1", wa.size());
    end
    seq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
            8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h38};
    send_seq();
    n_tests++;
    if ({32'(wa.size()), wa[2], wd[2], bus.LOAD_DONE} !==
        {32'd3, 32'h4, 32'h9ABC_DEF0, 1'b1}) begin
      n_fail++;
      $display("FAIL rmid_reload got n=%0d a=%h d=%h done=%b want 3 4 9abcdef0 1",
               wa.size(), wa[2], wd[2], bus.LOAD_DONE);
    end
  endtask

  initial begin
    bus.RX_DATA  = 8'h00;
    bus.RX_VALID = 1'b0;
    @(negedge CLK);
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_oversize();
    test_zero_length();
    test_start_as_data();
    test_timeout();
    test_gap_limit();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
